// File: rtl/rgmii_cal_pkg.sv
// Shared constants and types for the RGMII receive IDELAY calibrator.
package rgmii_cal_pkg;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;
    localparam int         TAP_W        = 5;
    localparam int         NUM_TAPS     = 32;
    localparam int         PRE_MAX      = 7;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LOAD      = 4'd1;
    localparam logic [3:0] ST_SETTLE    = 4'd2;
    localparam logic [3:0] ST_WAIT_IDLE = 4'd3;
    localparam logic [3:0] ST_MONITOR   = 4'd4;
    localparam logic [3:0] ST_NEXT      = 4'd5;
    localparam logic [3:0] ST_EVAL      = 4'd6;
    localparam logic [3:0] ST_APPLY     = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD      = ST_LOAD,
        S_SETTLE    = ST_SETTLE,
        S_WAIT_IDLE = ST_WAIT_IDLE,
        S_MONITOR   = ST_MONITOR,
        S_NEXT      = ST_NEXT,
        S_EVAL      = ST_EVAL,
        S_APPLY     = ST_APPLY,
        S_DONE      = ST_DONE
    } cal_state_t;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_PRE,
        CHK_SKIP
    } chk_state_t;

    // Centre of a tap window, rounding down for even lengths.
    function automatic logic [TAP_W-1:0] centre_tap(input logic [TAP_W-1:0] start,
                                                     input logic [TAP_W:0]   len);
        logic [TAP_W:0] half;
        half = (len - 6'd1) >> 1;
        return start + half[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/rgmii_rx_frame_chk.sv
// Scores each GMII frame by its preamble length and SFD; emits one good/bad pulse per frame.
module rgmii_rx_frame_chk
    import rgmii_cal_pkg::*;
#(
    parameter int unsigned MIN_PRE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       gmii_rx_dv,
    input  logic [7:0] gmii_rxd,
    output logic       frm_good,
    output logic       frm_bad
);

    localparam logic [2:0] MIN_PRE_C = 3'(MIN_PRE);
    localparam logic [2:0] PRE_MAX_C = 3'(PRE_MAX);

    chk_state_t state;
    logic [2:0] pre_cnt;
    logic [2:0] cur_cnt;

    assign cur_cnt = (state == CHK_PRE) ? pre_cnt : 3'd0;

    // CHK_IDLE with dv high is always a frame start: entry requires dv low beforehand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CHK_IDLE;
            pre_cnt  <= 3'd0;
            frm_good <= 1'b0;
            frm_bad  <= 1'b0;
        end else begin
            frm_good <= 1'b0;
            frm_bad  <= 1'b0;
            if (!en) begin
                state   <= CHK_IDLE;
                pre_cnt <= 3'd0;
            end else begin
                case (state)
                    CHK_IDLE, CHK_PRE: begin
                        if (!gmii_rx_dv) begin
                            if (state == CHK_PRE)
                                frm_bad <= 1'b1;
                            state   <= CHK_IDLE;
                            pre_cnt <= 3'd0;
                        end else if (gmii_rxd == ETH_PREAMBLE) begin
                            if (cur_cnt == PRE_MAX_C) begin
                                frm_bad <= 1'b1;
                                state   <= CHK_SKIP;
                            end else begin
                                pre_cnt <= cur_cnt + 3'd1;
                                state   <= CHK_PRE;
                            end
                        end else begin
                            if (gmii_rxd == ETH_SFD && cur_cnt >= MIN_PRE_C)
                                frm_good <= 1'b1;
                            else
                                frm_bad <= 1'b1;
                            state <= CHK_SKIP;
                        end
                    end
                    CHK_SKIP: begin
                        if (!gmii_rx_dv) begin
                            state   <= CHK_IDLE;
                            pre_cnt <= 3'd0;
                        end
                    end
                    default: begin
                        state   <= CHK_IDLE;
                        pre_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/rgmii_rx_dly_cal.sv
// Sweeps the shared RGMII RX IDELAY tap, scores each tap on received frames,
// then loads the centre of the longest passing window.
module rgmii_rx_dly_cal
    import rgmii_cal_pkg::*;
#(
    parameter logic [TAP_W-1:0] DEFAULT_TAP    = 5'd0,
    parameter int unsigned      SETTLE_CYC     = 16,
    parameter int unsigned      FRAMES_PER_TAP = 8,
    parameter int unsigned      MIN_PRE        = 2,
    parameter int unsigned      TIMEOUT_CYC    = 2**20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cal_start,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    output logic             dly_ld,
    output logic [TAP_W-1:0] dly_cntvalue,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_err,
    output logic [31:0]      pass_map
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int FRM_W = $clog2(FRAMES_PER_TAP + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    cal_state_t       state;
    logic [TAP_W-1:0] tap;
    logic [SET_W-1:0] settle_cnt;
    logic [FRM_W-1:0] frm_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TAP_W-1:0] scan_idx;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W:0]   run_len;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_len;
    logic [TAP_W-1:0] run_start_nx;
    logic [TAP_W:0]   run_len_nx;
    logic             frm_good;
    logic             frm_bad;
    logic             chk_en;

    assign chk_en = (state == S_MONITOR);

    rgmii_rx_frame_chk #(
        .MIN_PRE(MIN_PRE)
    ) u_frame_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (chk_en),
        .gmii_rx_dv(gmii_rx_dv),
        .gmii_rxd  (gmii_rxd),
        .frm_good  (frm_good),
        .frm_bad   (frm_bad)
    );

    // Run tracker for the window scan; a strict-greater update keeps the lowest start on ties.
    always_comb begin
        run_len_nx   = '0;
        run_start_nx = run_start;
        if (pass_map[scan_idx]) begin
            run_len_nx = run_len + 6'd1;
            if (run_len == '0)
                run_start_nx = scan_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tap          <= '0;
            settle_cnt   <= '0;
            frm_cnt      <= '0;
            tmo_cnt      <= '0;
            scan_idx     <= '0;
            run_start    <= '0;
            run_len      <= '0;
            best_start   <= '0;
            best_len     <= '0;
            dly_ld       <= 1'b0;
            dly_cntvalue <= DEFAULT_TAP;
            cal_busy     <= 1'b0;
            cal_done     <= 1'b0;
            cal_err      <= 1'b0;
            pass_map     <= '0;
        end else begin
            dly_ld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cal_start) begin
                        tap      <= '0;
                        pass_map <= '0;
                        cal_done <= 1'b0;
                        cal_err  <= 1'b0;
                        cal_busy <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dly_cntvalue <= tap;
                    dly_ld       <= 1'b1;
                    settle_cnt   <= '0;
                    state        <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1))
                        state <= S_WAIT_IDLE;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                S_WAIT_IDLE: begin
                    if (!gmii_rx_dv) begin
                        frm_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= S_MONITOR;
                    end
                end
                S_MONITOR: begin
                    if (frm_bad) begin
                        state <= S_NEXT;
                    end else if (frm_good && frm_cnt == FRM_W'(FRAMES_PER_TAP - 1)) begin
                        pass_map[tap] <= 1'b1;
                        state         <= S_NEXT;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        cal_err <= 1'b1;
                        state   <= S_NEXT;
                    end else begin
                        if (frm_good)
                            frm_cnt <= frm_cnt + 1'b1;
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (tap == LAST_TAP) begin
                        scan_idx   <= '0;
                        run_start  <= '0;
                        run_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                        state      <= S_EVAL;
                    end else begin
                        tap   <= tap + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_EVAL: begin
                    run_len   <= run_len_nx;
                    run_start <= run_start_nx;
                    if (run_len_nx > best_len) begin
                        best_len   <= run_len_nx;
                        best_start <= run_start_nx;
                    end
                    if (scan_idx == LAST_TAP)
                        state <= S_APPLY;
                    else
                        scan_idx <= scan_idx + 1'b1;
                end
                S_APPLY: begin
                    if (best_len != '0) begin
                        tap          <= centre_tap(best_start, best_len);
                        dly_cntvalue <= centre_tap(best_start, best_len);
                    end else begin
                        tap          <= DEFAULT_TAP;
                        dly_cntvalue <= DEFAULT_TAP;
                        cal_err      <= 1'b1;
                    end
                    dly_ld   <= 1'b1;
                    cal_busy <= 1'b0;
                    cal_done <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_rx_dly_cal.sv
// Randomized bench for rgmii_rx_dly_cal: a per-tap traffic generator plus a window-finding reference model.
module tb_rgmii_rx_dly_cal;

    localparam logic [4:0] DEF_TAP = 5'd6;
    localparam int         TMO     = 64;

    typedef enum int {M_GOOD, M_BAD_SFD, M_SHORT, M_LONG, M_JUNK, M_SILENT} mode_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cal_start;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        dly_ld;
    logic [4:0]  dly_cntvalue;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_err;
    logic [31:0] pass_map;

    mode_t tap_mode [32];
    int    checks   = 0;
    int    errors   = 0;
    int    ld_total = 0;

    rgmii_rx_dly_cal #(
        .DEFAULT_TAP   (DEF_TAP),
        .SETTLE_CYC    (16),
        .FRAMES_PER_TAP(8),
        .MIN_PRE       (2),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cal_start   (cal_start),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .dly_ld      (dly_ld),
        .dly_cntvalue(dly_cntvalue),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .cal_err     (cal_err),
        .pass_map    (pass_map)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dly_ld) ld_total <= ld_total + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
    endtask

    // Traffic source: frame shape is chosen from the mode of the tap in force when the frame starts.
    initial begin
        logic [7:0] frame[$];
        int         npre;
        mode_t      m;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        forever begin
            m = tap_mode[dly_cntvalue];
            frame.delete();
            case (m)
                M_GOOD, M_BAD_SFD: npre = $urandom_range(4, 2);
                M_SHORT:           npre = 1;
                M_LONG:            npre = 8;
                default:           npre = 0;
            endcase
            for (int i = 0; i < npre; i++) frame.push_back(8'h55);
            case (m)
                M_GOOD, M_SHORT, M_LONG: frame.push_back(8'hD5);
                M_BAD_SFD:               frame.push_back(8'hD4);
                M_JUNK:  for (int i = 0; i < 28; i++) frame.push_back(8'h00);
                default: ;
            endcase
            if (frame.size() != 0) frame.push_back(8'($urandom_range(255, 0)));
            if (frame.size() == 0) begin
                applyStimulus(1'b0, 8'h00);
            end else begin
                foreach (frame[i]) applyStimulus(1'b1, frame[i]);
                applyStimulus(1'b0, 8'h00);
            end
        end
    end

    // Reference: a tap passes iff it sees only good frames; pick the longest maximal run, lowest start on ties.
    function automatic void calcExpected(output logic [31:0] map, output logic [4:0] tap, output logic err);
        int best_len   = 0;
        int best_start = 0;
        map = '0;
        err = 1'b0;
        for (int t = 0; t < 32; t++) begin
            map[t] = (tap_mode[t] == M_GOOD);
            if (tap_mode[t] == M_SILENT) err = 1'b1;
        end
        for (int s = 0; s < 32; s++) begin
            if (map[s] && (s == 0 || !map[s-1])) begin
                int len;
                len = 0;
                while (s + len < 32 && map[s+len]) len++;
                if (len > best_len) begin
                    best_len   = len;
                    best_start = s;
                end
            end
        end
        if (best_len > 0) begin
            tap = 5'(best_start + (best_len - 1) / 2);
        end else begin
            tap = DEF_TAP;
            err = 1'b1;
        end
    endfunction

    task automatic setModes(input mode_t base);
        for (int t = 0; t < 32; t++) tap_mode[t] = base;
    endtask

    task automatic setRange(input int lo, input int hi, input mode_t m);
        for (int t = lo; t <= hi; t++) tap_mode[t] = m;
    endtask

    task automatic runScenario(input string name, input bit poke_start);
        logic [31:0] exp_map;
        logic [4:0]  exp_tap;
        logic        exp_err;
        int          ld0;
        int          cyc;
        calcExpected(exp_map, exp_tap, exp_err);
        ld0 = ld_total;
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
        checkOutput($sformatf("%s.busy_after_start", name), 32'(cal_busy), 32'd1);
        checkOutput($sformatf("%s.done_cleared", name), 32'(cal_done), 32'd0);
        if (poke_start) begin
            repeat ($urandom_range(400, 100)) @(posedge clk);
            #1 cal_start = 1'b1;
            @(posedge clk); #1 cal_start = 1'b0;
        end
        cyc = 0;
        while (!cal_done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput($sformatf("%s.done_in_time", name), 32'(cal_done), 32'd1);
        checkOutput($sformatf("%s.pass_map", name), pass_map, exp_map);
        checkOutput($sformatf("%s.tap", name), 32'(dly_cntvalue), 32'(exp_tap));
        checkOutput($sformatf("%s.err", name), 32'(cal_err), 32'(exp_err));
        checkOutput($sformatf("%s.busy_done", name), 32'(cal_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput($sformatf("%s.ld_pulses", name), 32'(ld_total - ld0), 32'd33);
        checkOutput($sformatf("%s.done_sticky", name), 32'(cal_done), 32'd1);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput($sformatf("%s.cntvalue", name), 32'(dly_cntvalue), 32'(DEF_TAP));
        checkOutput($sformatf("%s.ld", name), 32'(dly_ld), 32'd0);
        checkOutput($sformatf("%s.busy", name), 32'(cal_busy), 32'd0);
        checkOutput($sformatf("%s.done", name), 32'(cal_done), 32'd0);
        checkOutput($sformatf("%s.err", name), 32'(cal_err), 32'd0);
        checkOutput($sformatf("%s.map", name), pass_map, 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        cal_start = 1'b0;
        setModes(M_BAD_SFD);
        repeat (4) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;

        setModes(M_BAD_SFD); setRange(10, 20, M_GOOD);
        runScenario("win10_20", 1'b1);
        checkOutput("win10_20.map_const", pass_map, 32'h001FFC00);

        setModes(M_BAD_SFD); setRange(3, 6, M_GOOD); setRange(20, 27, M_GOOD);
        runScenario("two_windows", 1'b0);

        setModes(M_BAD_SFD); setRange(2, 5, M_GOOD); setRange(10, 13, M_GOOD);
        runScenario("equal_windows", 1'b0);

        setModes(M_BAD_SFD);
        runScenario("no_pass", 1'b0);

        setModes(M_BAD_SFD); setRange(28, 31, M_GOOD);
        runScenario("win_top", 1'b0);

        setModes(M_BAD_SFD); setRange(0, 0, M_GOOD);
        runScenario("win_zero", 1'b0);

        setModes(M_BAD_SFD); setRange(0, 7, M_JUNK); setRange(8, 15, M_GOOD);
        tap_mode[11] = M_SHORT;
        tap_mode[13] = M_LONG;
        runScenario("preamble_len", 1'b0);

        setModes(M_BAD_SFD); setRange(10, 20, M_GOOD); tap_mode[5] = M_SILENT;
        runScenario("timeout", 1'b0);

        // Abort a sweep while tap 3 is being monitored, after taps 0..2 have already passed.
        setModes(M_BAD_SFD); setRange(0, 2, M_GOOD); tap_mode[3] = M_SILENT;
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
        cyc = 0;
        while (dly_cntvalue != 5'd3 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("abort.reached_tap3", 32'(dly_cntvalue), 32'd3);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkResetValues("abort.in_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkResetValues("abort.after_release");

        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < 32; t++) begin
                case ($urandom_range(11, 0))
                    0, 1, 2, 3, 4, 5, 6: tap_mode[t] = M_GOOD;
                    7, 8:                tap_mode[t] = M_BAD_SFD;
                    9:                   tap_mode[t] = M_SHORT;
                    10:                  tap_mode[t] = M_LONG;
                    default:             tap_mode[t] = (r == 2) ? M_SILENT : M_BAD_SFD;
                endcase
            end
            runScenario($sformatf("random%0d", r), r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
